// File: rtl/alu_serial_seq_if.sv
// ----------------------------------------------------------------------------
// alu_serial_seq_if
// Request/response bundle between a client and the bit-serial ALU sequencer.
//   start, a, b, l, s, cin : operation request (client -> sequencer)
//   busy, done             : sequencer status
//   result, cout           : assembled result and final carry
//   zero, ovf              : result flags, present only when ALU_FLAGS_EN
//                            is defined
// Modports: master = client side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface alu_serial_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             l;
    logic [1:0]       s;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b, l, s, cin,
        input  busy, done, result, cout, zero, ovf
    );

    modport slave (
        input  start, a, b, l, s, cin,
        output busy, done, result, cout, zero, ovf
    );
`else
    modport master (
        output start, a, b, l, s, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, a, b, l, s, cin,
        output busy, done, result, cout
    );
`endif
endinterface

// File: rtl/alu_serial_seq.sv
// ----------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial sequencer wrapped around the 1-bit ALU slice (cal). An accepted
// start captures the operands; the slice is then fed one bit per cycle, LSB
// first, with its carry chained through a flop. Slice outputs are collected
// into a WIDTH-bit result and done pulses for one cycle when it is complete.
//
// Parameters:
//   WIDTH       operand/result width, also the number of RUN cycles (>=1)
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         alu_serial_seq_if.slave (start/a/b/l/s/cin in,
//               busy/done/result/cout out, zero/ovf with ALU_FLAGS_EN)
//   slice_a/b   operand bits to cal
//   slice_l/s   op select to cal
//   slice_cin   chained carry to cal
//   slice_out   result bit from cal
//   slice_cout  carry from cal
// Optional feature:
//   ALU_FLAGS_EN  adds registered zero and ovf flags on the interface
// ----------------------------------------------------------------------------
module alu_serial_seq #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_serial_seq_if.slave     bus,
    output logic                slice_a,
    output logic                slice_b,
    output logic                slice_l,
    output logic [1:0]          slice_s,
    output logic                slice_cin,
    input  logic                slice_out,
    input  logic                slice_cout
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             l_r;
    logic [1:0]       s_r;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;

    logic             accept;
    logic             last_bit;

    // A new request is only looked at when not running; DONE counts as ready
    // so back-to-back operations lose no cycle.
    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and bit-serial datapath. idx is cleared on the last bit
    // so it never points past the operand registers outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            l_r      <= 1'b0;
            s_r      <= 2'b00;
            carry    <= 1'b0;
            idx      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else if (accept) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            l_r      <= bus.l;
            s_r      <= bus.s;
            carry    <= bus.cin;
            idx      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else if (state == RUN) begin
            result_r[idx] <= slice_out;
            carry         <= slice_cout;
            if (last_bit) begin
                idx    <= '0;
                cout_r <= slice_cout;
            end else begin
                idx    <= idx + IDX_W'(1);
            end
        end
    end

    // Slice drive: only active in RUN, quiet zeros otherwise
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_l   = 1'b0;
        slice_s   = 2'b00;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = a_r[idx];
            slice_b   = b_r[idx];
            slice_l   = l_r;
            slice_s   = s_r;
            slice_cin = carry;
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.cout   = cout_r;

`ifdef ALU_FLAGS_EN
    logic [WIDTH-1:0] final_result;
    logic             zero_r;
    logic             ovf_r;

    // The MSB bit is still on slice_out during the last RUN cycle, so the
    // zero test looks at the result with that bit merged in.
    always_comb begin
        final_result      = result_r;
        final_result[idx] = slice_out;
    end

    // Flags update together with the last result bit. During the MSB cycle
    // the carry flop holds the carry into the MSB (cin when WIDTH is 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_bit) begin
            zero_r <= (final_result == '0);
            ovf_r  <= carry ^ slice_cout;
        end
    end

    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
`endif

endmodule
